// File: rtl/rs_synd_16_8.sv
// rs_synd_16_8: RS(16,8) syndrome calculator, GF(2^8) poly 0x11d, alpha = 0x02.
// Define RS_SYND_FRAME_CHK_EN to check din_eop framing and drive frame_err.

module gf256mul_dec #(
  parameter logic [7:0] B = 8'h02
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] prod;
  logic [7:0] shf;

  // Shift-and-add against a constant; synthesis folds this into an XOR network.
  always_comb begin
    prod = '0;
    shf  = a;
    for (int i = 0; i < 8; i++) begin
      if (B[i]) prod = prod ^ shf;
      shf = {shf[6:0], 1'b0} ^ (shf[7] ? 8'h1d : 8'h00);
    end
    y = prod;
  end

endmodule

// state | meaning
// IDLE  | no frame open, sym_cnt == 0, waiting for sop
// ACC   | frame open, sym_cnt symbols (1..15) accumulated
module rs_synd_16_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_val,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic [7:0]  din,
  output logic        synd_val,
  output logic [63:0] synd,
  output logic        synd_nz,
  output logic        frame_err
);

  localparam int N_NUM = 16;
  localparam int R_NUM = 8;
  localparam logic [8*R_NUM-1:0] ALPHA_POW = 64'h1d80_4020_1008_0402;

  typedef enum logic {IDLE, ACC} state_t;

  state_t     state, state_nxt;
  logic [7:0] sym_cnt, cnt_nxt;
  logic [7:0] acc     [R_NUM];
  logic [7:0] acc_mul [R_NUM];
  logic [7:0] acc_nxt [R_NUM];
  logic [8*R_NUM-1:0] synd_nxt;
  logic       start, step, complete;
`ifdef RS_SYND_FRAME_CHK_EN
  logic       err;
`else
  logic       unused_eop;
  assign unused_eop = din_eop;
`endif

  for (genvar j = 0; j < R_NUM; j++) begin : g_mul
    gf256mul_dec #(.B(ALPHA_POW[8*j +: 8])) u_mul (
      .a (acc[j]),
      .y (acc_mul[j])
    );
  end

  assign start = din_val && din_sop;
  assign step  = din_val && !din_sop && (state == ACC);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = sym_cnt;
    complete  = 1'b0;
`ifdef RS_SYND_FRAME_CHK_EN
    err       = 1'b0;
`endif
    if (start) begin
      state_nxt = ACC;
      cnt_nxt   = 8'd1;
`ifdef RS_SYND_FRAME_CHK_EN
      err       = (state == ACC);
`endif
    end else if (step) begin
      if (sym_cnt == 8'(N_NUM - 1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
`ifdef RS_SYND_FRAME_CHK_EN
        complete  = din_eop;
        err       = !din_eop;
`else
        complete  = 1'b1;
`endif
      end else begin
        cnt_nxt = sym_cnt + 8'd1;
`ifdef RS_SYND_FRAME_CHK_EN
        if (din_eop) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err       = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    synd_nxt = '0;
    for (int j = 0; j < R_NUM; j++) begin
      acc_nxt[j] = acc[j];
      if (start)
        acc_nxt[j] = din;
      else if (step)
        acc_nxt[j] = acc_mul[j] ^ din;
      synd_nxt[8*j +: 8] = acc_nxt[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sym_cnt  <= '0;
      for (int j = 0; j < R_NUM; j++) acc[j] <= '0;
      synd     <= '0;
      synd_val <= 1'b0;
      synd_nz  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sym_cnt  <= cnt_nxt;
      for (int j = 0; j < R_NUM; j++) acc[j] <= acc_nxt[j];
      synd_val <= complete;
      if (complete) begin
        synd    <= synd_nxt;
        synd_nz <= |synd_nxt;
      end
    end
  end

`ifdef RS_SYND_FRAME_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= err;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs_synd_16_8.sv
// tb_rs_synd_16_8: randomized frames checked against a polynomial-evaluation
// syndrome model (S_j = sum r_i * alpha^(j*i)).

module tb_rs_synd_16_8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_val = 1'b0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        synd_val;
  logic [63:0] synd;
  logic        synd_nz;
  logic        frame_err;

  rs_synd_16_8 dut (
    .clk       (clk),
    .rst       (rst),
    .din_val   (din_val),
    .din_sop   (din_sop),
    .din_eop   (din_eop),
    .din       (din),
    .synd_val  (synd_val),
    .synd      (synd),
    .synd_nz   (synd_nz),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

`ifdef RS_SYND_FRAME_CHK_EN
  localparam int FE_EN = 1;
`else
  localparam int FE_EN = 0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_cyc = 0;
  int fe_cnt = 0;
  logic [63:0] sv_q[$];
  logic        nz_q[$];
  int          cyc_q[$];
  logic [7:0]  cw [16];   // cw[i] = coefficient of x^i; cw[15] is sent first

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (synd_val) begin
      sv_q.push_back(synd);
      nz_q.push_back(synd_nz);
      cyc_q.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11d << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    repeat (e) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [63:0] synd_model();
    logic [63:0] res;
    logic [7:0]  s;
    res = '0;
    for (int j = 1; j <= 8; j++) begin
      s = 8'h00;
      for (int i = 0; i < 16; i++) s = s ^ gf_mul(cw[i], alpha_pow(j * i));
      res[8*(j-1) +: 8] = s;
    end
    return res;
  endfunction

  task automatic make_codeword();
    logic [7:0] g [9];
    logic [7:0] m [8];
    logic [7:0] aj;
    for (int i = 0; i < 9; i++) g[i] = (i == 0) ? 8'h01 : 8'h00;
    for (int j = 1; j <= 8; j++) begin
      aj = alpha_pow(j);
      for (int i = 8; i >= 0; i--)
        g[i] = gf_mul(g[i], aj) ^ ((i > 0) ? g[i-1] : 8'h00);
    end
    for (int i = 0; i < 8; i++) m[i] = 8'($urandom);
    for (int k = 0; k < 16; k++) begin
      cw[k] = 8'h00;
      for (int i = 0; i < 8; i++)
        if (k - i >= 0 && k - i <= 8) cw[k] = cw[k] ^ gf_mul(m[i], g[k-i]);
    end
  endtask

  task automatic random_cw();
    for (int i = 0; i < 16; i++) cw[i] = 8'($urandom);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    end
  endtask

  // Sends the first n_sym symbols of cw (highest degree first); eop on cw index eop_k.
  task automatic send_frame(input int gap_max, input int eop_k, input int n_sym);
    int k;
    int g;
    for (int n = 0; n < n_sym; n++) begin
      k = 15 - n;
      if (n > 0 && gap_max > 0) begin
        g = int'($urandom_range(gap_max));
        repeat (g) begin
          @(negedge clk);
          din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'($urandom);
        end
      end
      @(negedge clk);
      din_val = 1'b1; din_sop = (n == 0); din_eop = (k == eop_k); din = cw[k];
      last_cyc = cyc;
    end
  endtask

  task automatic pop_check(input string tag, input logic [63:0] exp_s, input int exp_cyc);
    logic [63:0] s;
    logic        nz;
    int          c;
    if (sv_q.size() > 0) begin
      s = sv_q.pop_front(); nz = nz_q.pop_front(); c = cyc_q.pop_front();
      chk({tag, "_synd"}, s, exp_s);
      chk({tag, "_nz"}, 64'(nz), 64'(exp_s != 64'h0));
      chk({tag, "_lat"}, 64'(c), 64'(exp_cyc));
    end
  endtask

  logic [63:0] exp_a, exp_b;
  int lc_a;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_val", 64'(synd_val), 64'd0);
    chk("rst_synd", synd, 64'd0);
    chk("rst_nz", 64'(synd_nz), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 16; i++) cw[i] = 8'h00;
    send_frame(0, 0, 16); idle(3);
    chk("zero_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("zero", 64'h0, last_cyc + 1);

    make_codeword();
    send_frame(0, 0, 16); idle(3);
    chk("cw_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("cw", 64'h0, last_cyc + 1);

    cw[0] = cw[0] ^ 8'h01;
    send_frame(0, 0, 16); idle(3);
    chk("cwerr_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("cwerr", 64'h0101_0101_0101_0101, last_cyc + 1);

    for (int i = 0; i < 16; i++) cw[i] = 8'h00;
    cw[15] = 8'h01;
    exp_a = synd_model();
    send_frame(0, 0, 16); idle(3);
    chk("r15_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("r15", exp_a, last_cyc + 1);
    chk("r15_s1", 64'(synd[7:0]), 64'h26);

    random_cw();
    exp_a = synd_model();
    send_frame(0, 0, 16); idle(3);
    chk("nogap_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("nogap", exp_a, last_cyc + 1);
    send_frame(3, 0, 16); idle(3);
    chk("gap_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("gap", exp_a, last_cyc + 1);

    random_cw();
    exp_a = synd_model();
    send_frame(0, 0, 16);
    lc_a = last_cyc;
    random_cw();
    exp_b = synd_model();
    send_frame(2, 0, 16); idle(3);
    chk("b2b_cnt", 64'(sv_q.size()), 64'd2);
    pop_check("b2b_a", exp_a, lc_a + 1);
    pop_check("b2b_b", exp_b, last_cyc + 1);
    idle(5);
    chk("hold_synd", synd, exp_b);

    repeat (3) begin
      @(negedge clk);
      din_val = 1'b1; din_sop = 1'b0; din_eop = 1'b0; din = 8'($urandom);
    end
    random_cw();
    send_frame(1, -1, 8);
    random_cw();
    exp_a = synd_model();
    send_frame(0, 0, 16); idle(3);
    chk("abort_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("abort", exp_a, last_cyc + 1);
    chk("abort_ferr", 64'(fe_cnt), 64'(FE_EN));

`ifdef RS_SYND_FRAME_CHK_EN
    random_cw();
    send_frame(0, 1, 15); idle(3);
    chk("eop15_cnt", 64'(sv_q.size()), 64'd0);
    chk("eop15_ferr", 64'(fe_cnt), 64'd2);
    chk("eop15_synd", synd, exp_a);
`endif

    random_cw();
    send_frame(0, -1, 7);
    @(negedge clk);
    rst = 1'b1; din_val = 1'b0; din_sop = 1'b0;
    @(negedge clk);
    chk("mrst_val", 64'(synd_val), 64'd0);
    chk("mrst_synd", synd, 64'd0);
    chk("mrst_nz", 64'(synd_nz), 64'd0);
    chk("mrst_ferr", 64'(frame_err), 64'd0);
    rst = 1'b0;
    idle(3);
    chk("mrst_cnt", 64'(sv_q.size()), 64'd0);

    random_cw();
    exp_a = synd_model();
    send_frame(1, 0, 16); idle(3);
    chk("post_cnt", 64'(sv_q.size()), 64'd1);
    pop_check("post", exp_a, last_cyc + 1);
    chk("ferr_total", 64'(fe_cnt), 64'(2 * FE_EN));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
